// File: rtl/exc_encoder.sv
// Commit-stage exception encoder/sequencer: prioritizes exceptions and interrupts, sequences flush and redirect.
// Optional EXC_INT_SYNC_EN adds a 2-flop synchronizer on the hardware interrupt lines.
module exc_encoder #(
    parameter int INT_NUM = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INT_NUM-1:0] HWInt_I,
    input  logic [INT_NUM-1:0] IM_I,
    input  logic               IE_I,
    input  logic               EXL_I,
    input  logic               Valid_I,
    input  logic [31:2]        PC_I,
    input  logic               InDelaySlot_I,
    input  logic               ExcAdEL_I,
    input  logic               ExcTLBL_I,
    input  logic               ExcTLBS_I,
    input  logic               ExcRI_I,
    input  logic               ExcSC_I,
    input  logic               ExcBP_I,
    input  logic               ERET_I,
    input  logic               Ack_I,
    output logic               Flush_O,
    output logic [6:2]         ExcCode_O,
    output logic [31:2]        EPC_O,
    output logic               BD_O,
    output logic               SetEXL_O,
    output logic               ClrEXL_O,
    output logic               ExcReq_O,
    output logic               EretReq_O
);

    typedef enum logic [1:0] {IDLE, FLUSH, REDIR} state_t;

    state_t             state, state_nxt;
    logic               kind_eret, kind_eret_nxt;
    logic               latch;
    logic [INT_NUM-1:0] hwint_s;
    logic               int_pend;
    logic               exc_any;
    logic [4:0]         code_nxt;

`ifdef EXC_INT_SYNC_EN
    logic [INT_NUM-1:0] hwint_p0, hwint_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hwint_p0 <= '0;
            hwint_p1 <= '0;
        end else begin
            hwint_p0 <= HWInt_I;
            hwint_p1 <= hwint_p0;
        end
    end

    assign hwint_s = hwint_p1;
`else
    assign hwint_s = HWInt_I;
`endif

    function automatic logic [4:0] exc_code(input logic intp, input logic adel,
                                            input logic tlbl, input logic tlbs,
                                            input logic ri, input logic sc,
                                            input logic bp);
        logic [4:0] c;
        c = 5'd0;
        if (intp)      c = 5'd0;
        else if (adel) c = 5'd4;
        else if (tlbl) c = 5'd2;
        else if (tlbs) c = 5'd3;
        else if (ri)   c = 5'd10;
        else if (sc)   c = 5'd8;
        else if (bp)   c = 5'd9;
        return c;
    endfunction

    assign int_pend = (|(hwint_s & IM_I)) & IE_I & ~EXL_I;
    assign exc_any  = int_pend | ExcAdEL_I | ExcTLBL_I | ExcTLBS_I |
                      ExcRI_I | ExcSC_I | ExcBP_I;
    assign code_nxt = exc_code(int_pend, ExcAdEL_I, ExcTLBL_I, ExcTLBS_I,
                               ExcRI_I, ExcSC_I, ExcBP_I);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            kind_eret <= 1'b0;
        end else begin
            state     <= state_nxt;
            kind_eret <= kind_eret_nxt;
        end
    end

    // Exceptions take precedence over ERET; a bare ERET leaves cause/EPC/BD alone
    always_comb begin
        state_nxt     = state;
        kind_eret_nxt = kind_eret;
        latch         = 1'b0;
        case (state)
            IDLE: begin
                if (Valid_I) begin
                    if (exc_any) begin
                        state_nxt     = FLUSH;
                        kind_eret_nxt = 1'b0;
                        latch         = 1'b1;
                    end else if (ERET_I) begin
                        state_nxt     = FLUSH;
                        kind_eret_nxt = 1'b1;
                    end
                end
            end
            FLUSH:   state_nxt = REDIR;
            REDIR:   if (Ack_I) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        Flush_O   = (state == FLUSH);
        SetEXL_O  = (state == FLUSH) & ~kind_eret;
        ClrEXL_O  = (state == FLUSH) &  kind_eret;
        ExcReq_O  = (state == REDIR) & ~kind_eret;
        EretReq_O = (state == REDIR) &  kind_eret;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ExcCode_O <= '0;
            EPC_O     <= '0;
            BD_O      <= 1'b0;
        end else if (latch) begin
            ExcCode_O <= code_nxt;
            EPC_O     <= InDelaySlot_I ? (PC_I - 30'd1) : PC_I;
            BD_O      <= InDelaySlot_I;
        end
    end

endmodule

// File: tb/tb_exc_encoder.sv
// Scoreboard bench for exc_encoder: commits push expected flush records, a negedge monitor pops and compares.
module tb_exc_encoder;

    localparam int INT_NUM = 6;
`ifdef EXC_INT_SYNC_EN
    localparam int INT_LAT = 3;
`else
    localparam int INT_LAT = 1;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic [INT_NUM-1:0] hwint, im;
    logic               ie, exl, valid, ds, eret, ack;
    logic [31:2]        pc;
    logic               adel, tlbl, tlbs, ri, sc, bp;
    logic               flush, bd, set_exl, clr_exl, exc_req, eret_req;
    logic [6:2]         code;
    logic [31:2]        epc;

    typedef struct packed {
        logic [4:0]  code;
        logic [29:0] epc;
        logic        bd;
        logic        eret;
    } exp_t;

    exp_t        sb[$];
    logic [4:0]  last_code;
    logic [29:0] last_epc;
    logic        last_bd;
    int          checks   = 0;
    int          failures = 0;

    exc_encoder #(.INT_NUM(INT_NUM)) dut (
        .clk(clk), .rst_n(rst_n), .HWInt_I(hwint), .IM_I(im), .IE_I(ie),
        .EXL_I(exl), .Valid_I(valid), .PC_I(pc), .InDelaySlot_I(ds),
        .ExcAdEL_I(adel), .ExcTLBL_I(tlbl), .ExcTLBS_I(tlbs), .ExcRI_I(ri),
        .ExcSC_I(sc), .ExcBP_I(bp), .ERET_I(eret), .Ack_I(ack),
        .Flush_O(flush), .ExcCode_O(code), .EPC_O(epc), .BD_O(bd),
        .SetEXL_O(set_exl), .ClrEXL_O(clr_exl), .ExcReq_O(exc_req),
        .EretReq_O(eret_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] model_code(input logic [5:0] fl);
        // fl = {AdEL, TLBL, TLBS, RI, SC, BP}
        if (fl[5]) return 5'd4;
        if (fl[4]) return 5'd2;
        if (fl[3]) return 5'd3;
        if (fl[2]) return 5'd10;
        if (fl[1]) return 5'd8;
        if (fl[0]) return 5'd9;
        return 5'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one commit, predict the outcome, and return one cycle after the sampling edge
    task automatic commit(input logic [29:0] p, input logic d, input logic [5:0] fl, input logic er);
        exp_t e;
        logic ip;
        ip = (|(hwint & im)) & ie & ~exl;
        pc = p; ds = d; eret = er; valid = 1'b1;
        {adel, tlbl, tlbs, ri, sc, bp} = fl;
        if (ip || fl != 6'd0) begin
            e.code = ip ? 5'd0 : model_code(fl);
            e.epc  = d ? (p - 30'd1) : p;
            e.bd   = d;
            e.eret = 1'b0;
            last_code = e.code; last_epc = e.epc; last_bd = e.bd;
            sb.push_back(e);
        end else if (er) begin
            e.code = last_code; e.epc = last_epc; e.bd = last_bd; e.eret = 1'b1;
            sb.push_back(e);
        end
        step();
        valid = 1'b0; ds = 1'b0; eret = 1'b0;
        {adel, tlbl, tlbs, ri, sc, bp} = 6'd0;
    endtask

    // Called in cycle N+1 with Ack_I=1: request lasts exactly one cycle
    task automatic finish_redir(input string tag, input logic is_eret);
        chk({tag, "_flush"}, flush, 1'b1);
        step();
        chk({tag, "_excreq"}, exc_req, !is_eret);
        chk({tag, "_eretreq"}, eret_req, is_eret);
        step();
        chk({tag, "_req_drop"}, exc_req | eret_req, 1'b0);
    endtask

    always @(negedge clk) begin
        chk("req_excl", exc_req & eret_req, 1'b0);
        if (flush) begin
            if (sb.size() == 0) begin
                chk("unexp_flush", flush, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_code", code, e.code);
                chk("sb_epc", epc, e.epc);
                chk("sb_bd", bd, e.bd);
                chk("sb_setexl", set_exl, !e.eret);
                chk("sb_clrexl", clr_exl, e.eret);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        logic [5:0]  fl_t [4] = '{6'b111001, 6'b001000, 6'b011000, 6'b000001};
        logic [29:0] pc_t [4] = '{30'h100, 30'h2000, 30'h3_0000, 30'h0};
        logic        ds_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        er_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; hwint = '0; im = '0; ie = 1'b0; exl = 1'b0; valid = 1'b0;
        ds = 1'b0; eret = 1'b0; ack = 1'b1; pc = '0;
        {adel, tlbl, tlbs, ri, sc, bp} = 6'd0;
        last_code = '0; last_epc = '0; last_bd = 1'b0;
        repeat (3) step();
        chk("rst_flush", flush, 1'b0);
        chk("rst_req", {exc_req, eret_req, set_exl, clr_exl}, 4'b0);
        chk("rst_code", code, 5'd0);
        chk("rst_epc", epc, 30'd0);
        chk("rst_bd", bd, 1'b0);
        rst_n = 1'b1;
        step();

        // Syscall, no delay slot
        commit(30'h0040_0010 >> 2, 1'b0, 6'b000010, 1'b0);
        chk("sc_code", code, 5'd8);
        chk("sc_epc", epc, 32'h0040_0010 >> 2);
        chk("sc_setexl", set_exl, 1'b1);
        finish_redir("sc", 1'b0);

        // Delay-slot RI
        commit(30'h0040_0024 >> 2, 1'b1, 6'b000100, 1'b0);
        chk("ri_code", code, 5'd10);
        chk("ri_bd", bd, 1'b1);
        chk("ri_epc", epc, 32'h0040_0020 >> 2);
        finish_redir("ri", 1'b0);

        // Priority mixes (first entry carries ERET), including EPC wrap at PC 0
        for (int i = 0; i < 4; i++) begin
            commit(pc_t[i], ds_t[i], fl_t[i], er_t[i]);
            finish_redir("prio", 1'b0);
        end
        chk("wrap_epc", epc, 32'h3FFF_FFFF);

        // Interrupt masked by EXL, then ERET held while Ack_I=0
        hwint = 6'b000100; im = 6'b000100; ie = 1'b1; exl = 1'b1;
        repeat (3) step();
        commit(30'h500, 1'b0, 6'd0, 1'b0);
        chk("mask_noflush", flush, 1'b0);
        step();
        ack = 1'b0;
        commit(30'h504, 1'b0, 6'd0, 1'b1);
        chk("eret_clrexl", clr_exl, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("eret_held", eret_req, 1'b1);
        end
        ack = 1'b1;
        step();
        chk("eret_drop", eret_req, 1'b0);
        exl = 1'b0;
        commit(30'h600, 1'b0, 6'd0, 1'b0);
        chk("int_code", code, 5'd0);
        hwint = '0;
        finish_redir("int", 1'b0);

        // Reset while ExcReq_O is high
        ack = 1'b0;
        commit(30'h700, 1'b0, 6'b000010, 1'b0);
        step();
        chk("pre_rst_req", exc_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {exc_req, eret_req, flush, set_exl, clr_exl}, 5'b0);
        chk("mid_rst_code", code, 5'd0);
        chk("mid_rst_epc", epc, 30'd0);
        last_code = '0; last_epc = '0; last_bd = 1'b0;
        step();
        rst_n = 1'b1;
        ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_idle", {flush, exc_req, eret_req}, 3'b0);
        end

        // Interrupt recognition latency with a valid commit every cycle
        hwint = '0; im = 6'b000100; ie = 1'b1; exl = 1'b0;
        repeat (4) step();
        begin
            exp_t e;
            e.code = 5'd0; e.epc = 30'h800; e.bd = 1'b0; e.eret = 1'b0;
            sb.push_back(e);
        end
        pc = 30'h800; valid = 1'b1; hwint = 6'b000100;
        first = -1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (flush && first < 0) begin
                first = k;
                valid = 1'b0;
                hwint = '0;
            end
        end
        valid = 1'b0; hwint = '0;
        chk("int_latency", first, INT_LAT);
        repeat (3) step();
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exc_encoder.md
# exc_encoder

Exception request encoder and sequencer on the CP0 side of the MIPS pipeline, at the commit (MEM/WB) boundary. It is the producer end of the exception-code path: it gathers synchronous exception flags and masked hardware interrupts, prioritizes them into a 5-bit ExcCode, and computes EPC/BD. It drives the pipeline flush and a held redirect request to fetch, whose target comes from the exception vector generator. It also sequences ERET returns.

## Interface
- INT_NUM, 6, number of hardware interrupt lines (IP7..IP2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- HWInt_I  in  INT_NUM  level-sensitive hardware interrupts
- IM_I  in  INT_NUM  Status.IM[7:2]
- IE_I  in  1  Status.IE
- EXL_I  in  1  Status.EXL
- Valid_I  in  1  a valid instruction is at commit this cycle
- PC_I  in  [31:2]  PC of committing instruction
- InDelaySlot_I  in  1  committing instruction is in a branch delay slot
- ExcAdEL_I, ExcTLBL_I, ExcTLBS_I, ExcRI_I, ExcSC_I, ExcBP_I  in  1 each  synchronous exception flags of committing instruction
- ERET_I  in  1  committing instruction is ERET
- Ack_I  in  1  fetch accepted the redirect
- Flush_O  out  1  kill all in-flight instructions (one-cycle pulse)
- ExcCode_O  out  [6:2]  encoded cause
- EPC_O  out  [31:2]  restart PC
- BD_O  out  1  Cause.BD value
- SetEXL_O, ClrEXL_O  out  1 each  one-cycle pulses to Status.EXL
- ExcReq_O  out  1  redirect to exception vector, held until Ack_I
- EretReq_O  out  1  redirect to EPC, held until Ack_I

## Operation
- States: IDLE, FLUSH, REDIR.
- IDLE: commit is sampled only when Valid_I=1.
  - Interrupt pending = |(HWInt_s & IM_I) & IE_I & ~EXL_I.
  - Event priority: INT(0) > AdEL(4) > TLBL(2) > TLBS(3) > RI(10) > SC(8) > BP(9) > ERET.
  - Exception event: latch ExcCode_O. BD_O = InDelaySlot_I. EPC_O = InDelaySlot_I ? PC_I-1 (word, i.e. PC-4) : PC_I. Set kind=EXC. Go to FLUSH.
  - Interrupt event: committing instruction is not executed. Its PC is used with the same EPC/BD rule.
  - ERET with no exception flag: set kind=ERET. Go to FLUSH. ExcCode_O, EPC_O and BD_O are unchanged.
- FLUSH (1 cycle): Flush_O=1.
  - EXC: SetEXL_O=1.
  - ERET: ClrEXL_O=1.
  - Go to REDIR.
- REDIR: ExcReq_O=1 (EXC) or EretReq_O=1 (ERET) until Ack_I=1 is sampled, then IDLE.
- Valid_I, flags and ERET_I are ignored outside IDLE.
- ExcCode_O, EPC_O and BD_O hold their values until the next exception event.
- PC arithmetic wraps modulo 2^30 words.

## Timing
- Reset (async assert, sync release): state=IDLE, all outputs 0, synchronizer flops 0.
- Commit sampled at edge N. Flush_O, SetEXL_O/ClrEXL_O and the new ExcCode_O/EPC_O/BD_O are valid in cycle N+1. ExcReq_O/EretReq_O rise in cycle N+2.
- Ack_I high in the first REDIR cycle: request lasts exactly 1 cycle, IDLE at N+3.
- Ack_I outside REDIR is ignored.
- ExcReq_O and EretReq_O are never both high.
- Simultaneous events:
  - Multiple flags: highest priority wins.
  - Flag together with ERET_I: exception wins.
  - Interrupt with EXL_I=1: masked, so ERET proceeds. The interrupt is taken at the first valid commit after EXL clears.
- Reset mid-REDIR aborts the request immediately.

## Configuration
- EXC_INT_SYNC_EN defined: HWInt_I passes through a 2-flop synchronizer, giving HWInt_s. This adds 2 cycles of interrupt recognition latency.
- EXC_INT_SYNC_EN undefined: HWInt_s = HWInt_I, sampled directly.

## Test plan
- Syscall, no delay slot: Valid_I=1, ExcSC_I=1, PC_I=0x00400010>>2, Ack_I tied 1.
  - Required: N+1 Flush_O=1, SetEXL_O=1, ExcCode_O=8, EPC_O=0x00400010>>2, BD_O=0.
  - Required: N+2 ExcReq_O=1 for one cycle.
- Delay-slot RI: InDelaySlot_I=1, PC_I=0x00400024>>2, ExcRI_I=1.
  - Required: ExcCode_O=10, BD_O=1, EPC_O=0x00400020>>2.
- Priority: ExcAdEL_I, ExcTLBL_I and ExcBP_I all 1 together with ERET_I=1.
  - Required: ExcCode_O=4, ExcReq_O asserted, EretReq_O stays 0.
- Interrupt masking: HWInt_I[2]=1, IE_I=1, EXL_I=1.
  - Required: no event.
  - Then ERET commits: ClrEXL_O pulse, EretReq_O held 3 cycles while Ack_I=0, dropped after Ack_I.
  - Then EXL_I=0, IM_I[2]=1, next valid commit: ExcCode_O=0.
- Reset mid-REDIR: rst_n low while ExcReq_O=1.
  - Required: all outputs 0 immediately. No activity after release until a new valid commit.
- EXC_INT_SYNC_EN defined: HWInt_I rises at edge N with a valid commit every cycle.
  - Required: Flush_O first asserted at N+3, versus N+1 without the macro.
